masked_dense_layer_seq: RTL and testbench
=========================================

Name: masked_dense_layer_seq

Overview:
Time-multiplexed, arithmetically masked dense layer: y[j] = b[j] + sum_i w[j][i]*x[i] for N_OUT neurons over N_IN inputs.
- Inputs and outputs are carried as two additive shares (x = x0 + x1 mod 2^ACC_W); no unmasked intermediate is ever formed.
- One masked MAC per cycle. Weights and biases come from an external synchronous weight memory.
- Successor to the fixed, combinational two-layer network: depth, widths and masking are parametrised, and layers are chained by instancing this block per layer.

Parameters:
- N_IN, 10, inputs per neuron (>=1)
- N_OUT, 10, neurons in the layer (>=1)
- WIDTH, 16, signed two's-complement weight/bias width
- FRAC, 8, fractional bits of weights/inputs; bias is aligned as bias<<FRAC
- MASKED, 1, 1 = two-share operation; 0 = in_x1 and rnd are treated as 0
- (localparam) ACC_W = 2*WIDTH + clog2(N_IN+1); width of every share
- (localparam) AW = clog2(N_OUT*(N_IN+1)); weight address width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a layer evaluation; ignored unless IDLE
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after the last neuron is accepted
- in_valid  in  1  input share pair valid
- in_ready  out  1  high only in LOAD
- in_x0  in  ACC_W  input share 0
- in_x1  in  ACC_W  input share 1
- w_rd  out  1  weight memory read strobe
- w_addr  out  AW  address = j*(N_IN+1)+k; k = N_IN selects bias[j]
- w_data  in  WIDTH  signed data, valid exactly 1 cycle after w_rd
- rnd  in  ACC_W  fresh randomness, sampled on entry to OUT
- out_valid  out  1  output share pair valid
- out_ready  in  1  downstream accept
- out_idx  out  clog2(N_OUT)  neuron index j of the current output
- out_y0  out  ACC_W  output share 0
- out_y1  out  ACC_W  output share 1

Behaviour:
- Reset (asynchronous, any state): state=IDLE; counters, accumulators and the input buffer are cleared. All outputs are 0: busy, done, in_ready, w_rd, w_addr, out_valid, out_idx, out_y0, out_y1.
- IDLE: start=1 moves to LOAD with i=0.
- LOAD: in_ready=1. Each in_valid&in_ready stores (x0, x1) into buffer[i] and increments i. After the N_IN-th handshake the block enters MAC with j=0, k=0 and both accumulators cleared. No backpressure timeout.
- MAC: w_rd=1 and w_addr=j*(N_IN+1)+k for k=0..N_IN, one address per cycle.
  - The cycle after address k<N_IN is issued: acc_s += sext(w_data)*buffer[k].s for s=0,1, taken mod 2^ACC_W (keep the low ACC_W bits of the product).
  - After k=N_IN is issued, go to DRAIN.
- DRAIN (1 cycle, w_rd=0): acc_0 += sext(w_data)<<FRAC (bias goes to share 0 only). Go to OUT.
- OUT: registered on entry:
  - out_y0 = acc_0 + rnd
  - out_y1 = acc_1 - rnd (mod 2^ACC_W)
  - out_idx = j; out_valid=1
  Outputs are held stable until out_ready. On the handshake, if j<N_OUT-1: j++, accumulators are cleared, state goes to MAC. Otherwise done pulses for 1 cycle and state goes to IDLE. out_valid drops in the cycle after the handshake.
- Latency: per neuron, N_IN+2 cycles from MAC entry to out_valid.
- Invariant: (out_y0+out_y1) mod 2^ACC_W = b<<FRAC + sum w*x, exact with no saturation. Rescaling and activation happen downstream on recombined or re-masked data.
- MASKED=0: in_x1 and rnd are forced to 0, acc_1 stays 0 and out_y1=0.
- Simultaneous events:
  - start while busy is ignored.
  - in_valid outside LOAD is ignored.
  - out_ready while out_valid=0 has no effect.
  - Reset during OUT discards the pending neuron.
- w_data is only sampled in the cycle after w_rd; any other value is don't-care.

Decomposition:
- Package nn_pkg holds: the state enum (IDLE, LOAD, MAC, DRAIN, OUT); function acc_w(width, n_in); and the share-pair struct typedef.
- Sub-module share_mac: one modular multiply-accumulate per share, instanced twice. Ports: clk, rst, clr, en, w, x, acc.

Test Plan:
- Bench config: N_IN=3, N_OUT=2, WIDTH=8, FRAC=0, so ACC_W=18.
- Unmasked: x={1,2,3} (x1=0); w0={1,1,1}, b0=4; rnd=0 -> out_idx=0, y0=10, y1=0; first out_valid 5 cycles after MAC entry.
- Refresh: same as above with rnd=5 -> y0=15, y1=0x3FFFB; sum mod 2^18 = 10.
- Masked inputs: x0={0x3FFFF,5,7}, x1={2,0x3FFFD,0x3FFFC}; w1={-1,2,-3}, b1=0 -> neuron 1 y0+y1 mod 2^18 = 0x3FFFA (-6); done pulses after the second accept.
- Backpressure: hold out_ready=0 for 10 cycles in OUT -> out_y0, out_y1, out_idx stable, no w_rd issued; then accept -> MAC restarts with j=1.
- Reset mid-MAC of neuron 1 -> all outputs 0 next cycle; a new start reloads inputs and neuron 0 output repeats the expected value.
- Protocol: start during MAC and in_valid during OUT -> no state change; w_addr sequence is 0,1,2,3 then 4,5,6,7.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared types and sizing helpers for the masked dense-layer datapath.
package nn_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    MAC,
    DRAIN,
    OUT
  } state_t;

  // Share width: a full WIDTH x WIDTH product plus headroom for N_IN terms and the bias.
  function automatic int acc_w(input int width, input int n_in);
    return 2 * width + $clog2(n_in + 1);
  endfunction

  localparam int SHARE_W_MAX = 64;

  typedef struct packed {
    logic [SHARE_W_MAX-1:0] s0;
    logic [SHARE_W_MAX-1:0] s1;
  } share_pair_t;

endpackage

// File: rtl/share_mac.sv
// Modular multiply-accumulate on one arithmetic share; wraps mod 2^W.
module share_mac #(
  parameter int W = 18
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] w,
  input  logic [W-1:0] x,
  output logic [W-1:0] acc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      acc <= '0;
    else if (clr) acc <= '0;
    else if (en)  acc <= acc + w * x;
  end

endmodule

// File: rtl/masked_dense_layer_seq.sv
// Time-multiplexed dense layer on two additive shares, one masked MAC per cycle.
// state | meaning
// IDLE  | waiting for start
// LOAD  | collecting N_IN input share pairs
// MAC   | issuing weight addresses k=0..N_IN for neuron j
// DRAIN | last weight-memory word (bias) arrives
// OUT   | re-masked result held until out_ready
module masked_dense_layer_seq
  import nn_pkg::*;
#(
  parameter int N_IN   = 10,
  parameter int N_OUT  = 10,
  parameter int WIDTH  = 16,
  parameter int FRAC   = 8,
  parameter int MASKED = 1,
  localparam int ACC_W = acc_w(WIDTH, N_IN),
  localparam int AW    = $clog2(N_OUT * (N_IN + 1)),
  localparam int IW    = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [ACC_W-1:0] in_x0,
  input  logic [ACC_W-1:0] in_x1,
  output logic             w_rd,
  output logic [AW-1:0]    w_addr,
  input  logic [WIDTH-1:0] w_data,
  input  logic [ACC_W-1:0] rnd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IW-1:0]    out_idx,
  output logic [ACC_W-1:0] out_y0,
  output logic [ACC_W-1:0] out_y1
);

  localparam int KW = $clog2(N_IN + 1);
  localparam int BW = (N_IN > 1) ? $clog2(N_IN) : 1;

  state_t state, state_nxt;

  logic [BW-1:0]    i_q;
  logic [KW-1:0]    k_q;
  logic [BW-1:0]    kd_q;
  logic             prod_en_q;
  logic [IW-1:0]    j_q;
  logic [AW-1:0]    addr_q;
  logic [ACC_W-1:0] buf0 [N_IN];
  logic [ACC_W-1:0] buf1 [N_IN];
  logic [ACC_W-1:0] acc0, acc1, w_ext, bias_ext, rnd_m, x1_m;
  logic             load_hs, out_hs, last_in, last_k, last_j, acc_clr;

  assign w_ext    = {{(ACC_W - WIDTH){w_data[WIDTH-1]}}, w_data};
  assign bias_ext = w_ext << FRAC;
  assign rnd_m    = (MASKED != 0) ? rnd : '0;
  assign x1_m     = (MASKED != 0) ? in_x1 : '0;

  assign load_hs  = (state == LOAD) && in_valid;
  assign out_hs   = (state == OUT) && out_ready;
  assign last_in  = (i_q == BW'(N_IN - 1));
  assign last_k   = (k_q == KW'(N_IN));
  assign last_j   = (j_q == IW'(N_OUT - 1));
  assign acc_clr  = (load_hs && last_in) || (out_hs && !last_j);

  assign out_valid = (state == OUT);
  assign w_addr    = w_rd ? addr_q : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    in_ready  = 1'b0;
    w_rd      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = LOAD;
      end
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid && last_in) state_nxt = MAC;
      end
      MAC: begin
        w_rd = 1'b1;
        if (last_k) state_nxt = DRAIN;
      end
      DRAIN:   state_nxt = OUT;
      OUT:     if (out_ready) state_nxt = last_j ? IDLE : MAC;
      default: state_nxt = IDLE;
    endcase
  end

  // Bias is folded straight into the output load so OUT follows DRAIN directly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_q       <= '0;
      k_q       <= '0;
      kd_q      <= '0;
      prod_en_q <= 1'b0;
      j_q       <= '0;
      addr_q    <= '0;
      done      <= 1'b0;
      out_idx   <= '0;
      out_y0    <= '0;
      out_y1    <= '0;
    end else begin
      done      <= out_hs && last_j;
      prod_en_q <= (state == MAC) && !last_k;
      kd_q      <= k_q[BW-1:0];
      if ((state == IDLE) && start) i_q <= '0;
      else if (load_hs)             i_q <= i_q + 1'b1;
      if (load_hs && last_in) begin
        j_q    <= '0;
        k_q    <= '0;
        addr_q <= '0;
      end else if (state == MAC) begin
        k_q    <= k_q + 1'b1;
        addr_q <= addr_q + 1'b1;
      end else if (out_hs && !last_j) begin
        j_q <= j_q + 1'b1;
        k_q <= '0;
      end
      if (state == DRAIN) begin
        out_y0  <= acc0 + bias_ext + rnd_m;
        out_y1  <= acc1 - rnd_m;
        out_idx <= j_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < N_IN; n++) begin
        buf0[n] <= '0;
        buf1[n] <= '0;
      end
    end else if (load_hs) begin
      buf0[i_q] <= in_x0;
      buf1[i_q] <= x1_m;
    end
  end

  share_mac #(.W(ACC_W)) u_mac0 (
    .clk (clk),
    .rst (rst),
    .clr (acc_clr),
    .en  (prod_en_q),
    .w   (w_ext),
    .x   (buf0[kd_q]),
    .acc (acc0)
  );

  share_mac #(.W(ACC_W)) u_mac1 (
    .clk (clk),
    .rst (rst),
    .clr (acc_clr),
    .en  (prod_en_q),
    .w   (w_ext),
    .x   (buf1[kd_q]),
    .acc (acc1)
  );

endmodule

// File: tb/tb_masked_dense_layer_seq.sv
// Randomised bench for masked_dense_layer_seq against a plain-arithmetic reference.
module tb_masked_dense_layer_seq;
  import nn_pkg::*;

  localparam int N_IN  = 3;
  localparam int N_OUT = 2;
  localparam int WIDTH = 8;
  localparam int FRAC  = 0;
  localparam int ACC_W = 18;
  localparam int AW    = 3;
  localparam int IW    = 1;
  localparam longint MASK = (longint'(1) << ACC_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             busy, done;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [ACC_W-1:0] in_x0 = '0, in_x1 = '0, rnd = '0;
  logic             w_rd;
  logic [AW-1:0]    w_addr;
  logic [WIDTH-1:0] w_data;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [IW-1:0]    out_idx;
  logic [ACC_W-1:0] out_y0, out_y1;

  int n_checks = 0;
  int n_pass   = 0;

  logic signed [WIDTH-1:0] mem [N_OUT*(N_IN+1)];
  logic [ACC_W-1:0] xs0 [N_IN];
  logic [ACC_W-1:0] xs1 [N_IN];
  logic [ACC_W-1:0] rnd_val [N_OUT];
  logic [ACC_W-1:0] obs_y0 [N_OUT];
  logic [ACC_W-1:0] obs_y1 [N_OUT];
  bit rand_rnd;

  masked_dense_layer_seq #(
    .N_IN(N_IN), .N_OUT(N_OUT), .WIDTH(WIDTH), .FRAC(FRAC), .MASKED(1)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .in_valid(in_valid), .in_ready(in_ready), .in_x0(in_x0), .in_x1(in_x1),
    .w_rd(w_rd), .w_addr(w_addr), .w_data(w_data), .rnd(rnd),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
    .out_y0(out_y0), .out_y1(out_y1)
  );

  always #5 clk = ~clk;

  // Synchronous weight memory; garbage on the bus whenever no read was issued.
  always @(posedge clk) w_data <= w_rd ? mem[w_addr] : WIDTH'($urandom);

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, expected run to finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic share_pair_t model_pair(input int j, input logic [ACC_W-1:0] r);
    longint a0, a1;
    share_pair_t p;
    a0 = longint'(mem[j*(N_IN+1)+N_IN]) <<< FRAC;
    a1 = 0;
    for (int i = 0; i < N_IN; i++) begin
      a0 += longint'(mem[j*(N_IN+1)+i]) * longint'(xs0[i]);
      a1 += longint'(mem[j*(N_IN+1)+i]) * longint'(xs1[i]);
    end
    p.s0 = (a0 + longint'(r)) & MASK;
    p.s1 = (a1 - longint'(r)) & MASK;
    return p;
  endfunction

  function automatic longint model_total(input int j);
    longint t;
    t = longint'(mem[j*(N_IN+1)+N_IN]) <<< FRAC;
    for (int i = 0; i < N_IN; i++)
      t += longint'(mem[j*(N_IN+1)+i]) * ((longint'(xs0[i]) + longint'(xs1[i])) & MASK);
    return t & MASK;
  endfunction

  task automatic run_layer(input int hold, input bit poke, input int abort_j);
    int lat, exp_addr, nrd;
    longint sum;
    share_pair_t p;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("load_ready", in_ready, 1);
    for (int i = 0; i < N_IN; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      in_valid = 1'b1;
      in_x0 = xs0[i];
      in_x1 = xs1[i];
      tick();
      in_valid = 1'b0;
      in_x0 = ACC_W'($urandom);
      in_x1 = ACC_W'($urandom);
    end
    exp_addr = 0;
    for (int j = 0; j < N_OUT; j++) begin
      rnd = rand_rnd ? ACC_W'($urandom) : rnd_val[j];
      lat = 0;
      nrd = 0;
      while (!out_valid && lat < 20) begin
        if (w_rd) begin
          check("w_addr", w_addr, exp_addr);
          exp_addr++;
          nrd++;
        end
        if (j == abort_j && lat == 2) begin
          rst = 1'b1;
          #1;
          check("rst_outs", {busy, done, in_ready, w_rd, w_addr, out_valid, out_idx, out_y0, out_y1}, 0);
          start = 1'b0;
          out_ready = 1'b0;
          tick();
          rst = 1'b0;
          tick();
          return;
        end
        start = poke && (lat == 1);
        out_ready = 1'($urandom_range(0, 1));
        tick();
        lat++;
      end
      start = 1'b0;
      out_ready = 1'b0;
      check("latency", lat, N_IN + 2);
      check("reads", nrd, N_IN + 1);
      p = model_pair(j, rnd);
      check("out_idx", out_idx, j);
      check("out_y0", out_y0, p.s0);
      check("out_y1", out_y1, p.s1);
      sum = (longint'(out_y0) + longint'(out_y1)) & MASK;
      check("recombined", sum, model_total(j));
      obs_y0[j] = out_y0;
      obs_y1[j] = out_y1;
      for (int h = 0; h < hold; h++) begin
        in_valid = poke;
        start = poke;
        if (rand_rnd || poke) rnd = ACC_W'($urandom);
        tick();
        check("hold_stable", {out_valid, w_rd, in_ready, out_idx, out_y0, out_y1},
              {1'b1, 1'b0, 1'b0, IW'(j), p.s0[ACC_W-1:0], p.s1[ACC_W-1:0]});
      end
      in_valid = 1'b0;
      start = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("valid_drop", out_valid, 0);
      if (j == N_OUT - 1) begin
        check("done_set", {done, busy}, 2'b10);
        tick();
        check("done_pulse", done, 0);
      end else begin
        check("next_mac", {done, busy, w_rd}, 3'b011);
      end
    end
  endtask

  initial begin
    repeat (3) tick();
    check("rst_hold", {busy, done, in_ready, w_rd, w_addr, out_valid, out_idx, out_y0, out_y1}, 0);
    rst = 1'b0;
    tick();
    check("idle", {busy, done, in_ready, w_rd, w_addr, out_valid, out_idx, out_y0, out_y1}, 0);

    // Plain inputs, neuron 0 = 1+2+3+4, neuron 1 = -1+4-9
    mem = '{8'sd1, 8'sd1, 8'sd1, 8'sd4, -8'sd1, 8'sd2, -8'sd3, 8'sd0};
    xs0 = '{18'd1, 18'd2, 18'd3};
    xs1 = '{18'd0, 18'd0, 18'd0};
    rnd_val = '{18'd0, 18'd0};
    rand_rnd = 1'b0;
    run_layer(0, 1'b0, -1);
    check("plain_y0", obs_y0[0], 18'd10);
    check("plain_y1", obs_y1[0], 18'd0);
    check("plain_n1", obs_y0[1], 18'h3FFFA);

    // Mask refresh plus backpressure and ignored start/in_valid
    rnd_val = '{18'd5, 18'h01234};
    run_layer(10, 1'b1, -1);
    check("refresh_y0", obs_y0[0], 18'd15);
    check("refresh_y1", obs_y1[0], 18'h3FFFB);

    // Genuinely split inputs that recombine to {1,2,3}
    xs0 = '{18'h3FFFF, 18'd5, 18'd7};
    xs1 = '{18'd2, 18'h3FFFD, 18'h3FFFC};
    rnd_val = '{18'h2A5A5, 18'h15A5A};
    run_layer(2, 1'b0, -1);
    check("masked_n1", (longint'(obs_y0[1]) + longint'(obs_y1[1])) & MASK, 18'h3FFFA);

    // Abort in neuron 1, then a fresh run must reproduce neuron 0
    run_layer(0, 1'b0, 1);
    check("post_rst_idle", {busy, out_valid, w_rd}, 3'b000);
    run_layer(1, 1'b0, -1);
    check("rerun_n0", (longint'(obs_y0[0]) + longint'(obs_y1[0])) & MASK, 18'd10);

    rand_rnd = 1'b1;
    for (int t = 0; t < 8; t++) begin
      for (int a = 0; a < N_OUT*(N_IN+1); a++) mem[a] = WIDTH'($urandom);
      for (int i = 0; i < N_IN; i++) begin
        xs0[i] = ACC_W'($urandom);
        xs1[i] = ACC_W'($urandom);
      end
      run_layer($urandom_range(0, 3), 1'($urandom_range(0, 1)), -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
